step_seq_ctrl: RTL and testbench

STEP_SEQ_CTRL -- requirements
Module: step_seq_ctrl

---
 rtl/step_seq_ctrl.sv | 113 +++++++++++
 tb/tb_step_seq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_seq_ctrl.sv
// Two-requester step sequencer. A granted job latches its direction and step
// count, then walks a shared 4-bit counter up or down once per cycle. It
// signals completion on the owner's ack until that owner withdraws its request.
module step_seq_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       mode0,
  input  logic [3:0] steps0,
  input  logic       req1,
  input  logic       mode1,
  input  logic [3:0] steps1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic       owner,
  output logic       dir,
  output logic [3:0] count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       dir_q, dir_d;
  logic       last_q, last_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] count_q, count_d;
  logic       grant_id;
  logic       req_owner;

  // Next-state and datapath updates; every register holds unless its state acts on it
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    dir_d     = dir_q;
    last_d    = last_q;
    rem_d     = rem_q;
    count_d   = count_q;
    grant_id  = 1'b0;
    req_owner = owner_q ? req1 : req0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On contention the requester that did not finish last wins;
          // otherwise the single active requester (req1 alone selects 1).
          grant_id = (req0 && req1) ? ~last_q : req1;
          owner_d  = grant_id;
          dir_d    = grant_id ? mode1 : mode0;
          rem_d    = grant_id ? steps1 : steps0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        state_d = (rem_q == 4'd0) ? DONE : RUN;
      end
      RUN: begin
        // Counter wraps naturally in 4 bits in both directions
        count_d = dir_q ? (count_q - 4'd1) : (count_q + 4'd1);
        rem_d   = rem_q - 4'd1;
        if (rem_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Requests are only looked at again once the owner lets go
        if (!req_owner) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and job registers; reset also aborts any job in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      dir_q   <= 1'b0;
      last_q  <= 1'b1;
      rem_q   <= 4'd0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      count_q <= count_d;
    end
  end

  // Outputs are pure decodes of registered state
  assign busy  = (state_q == LOAD) || (state_q == RUN);
  assign ack0  = (state_q == DONE) && !owner_q;
  assign ack1  = (state_q == DONE) && owner_q;
  assign owner = owner_q;
  assign dir   = dir_q;
  assign count = count_q;
  assign state = state_q;

endmodule

// File: tb/tb_step_seq_ctrl.sv
// Bench for step_seq_ctrl: stimulus pushes expected job results into a queue,
// an independent monitor pops one entry per ack rising edge and compares.
module tb_step_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, mode0, req1, mode1;
  logic [3:0] steps0, steps1;
  logic       ack0, ack1, busy, owner, dir;
  logic [3:0] count;
  logic [1:0] state;

  step_seq_ctrl dut (
    .clock (clock),
    .reset (reset),
    .req0  (req0),
    .mode0 (mode0),
    .steps0(steps0),
    .req1  (req1),
    .mode1 (mode1),
    .steps1(steps1),
    .ack0  (ack0),
    .ack1  (ack1),
    .busy  (busy),
    .owner (owner),
    .dir   (dir),
    .count (count),
    .state (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         owner;
    bit         dir;
    logic [3:0] count;
    int         n;
  } exp_t;

  exp_t       exp_q[$];
  int         n_total = 0;
  int         n_pass  = 0;
  logic [3:0] mcount;
  bit         mlast;
  int         busy_cnt = 0;
  bit         ack_prev = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, input string name);
    for (int i = 0; i < limit && state !== s; i++) tick();
    if (state !== s) begin
      n_total++;
      $display("FAIL %s: timeout, state got %0d, required %0d", name, state, s);
    end
  endtask

  task automatic wait_ack(input bit r, input int limit, input string name);
    for (int i = 0; i < limit && (r ? ack1 : ack0) !== 1'b1; i++) tick();
    if ((r ? ack1 : ack0) !== 1'b1) begin
      n_total++;
      $display("FAIL %s: timeout, ack%0d got 0, required 1", name, r);
    end
  endtask

  // Reference model: a job of s steps moves the counter by s in its direction
  task automatic push_exp(input bit r, input bit m, input logic [3:0] s);
    exp_t e;
    mcount  = m ? (mcount - s) : (mcount + s);
    e.owner = r;
    e.dir   = m;
    e.count = mcount;
    e.n     = int'(s);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    mcount = 4'd0;
    mlast  = 1'b1;
  endtask

  task automatic job1(input bit r, input bit m, input logic [3:0] s,
                      input int hold, input bit early);
    logic [3:0] fin;
    push_exp(r, m, s);
    fin = mcount;
    if (r) begin req1 = 1'b1; mode1 = m; steps1 = s; end
    else   begin req0 = 1'b1; mode0 = m; steps0 = s; end
    wait_state(2'b01, 5, "job1_load");
    // Inputs other than the owner's request must be ignored once granted
    if (r) begin mode1 = 1'($urandom); steps1 = 4'($urandom); end
    else   begin mode0 = 1'($urandom); steps0 = 4'($urandom); end
    if (early) begin
      if (r) req1 = 1'b0; else req0 = 1'b0;
    end
    wait_ack(r, 40, "job1_ack");
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_state", int'(state), 3);
        chk("hold_ack", int'(r ? ack1 : ack0), 1);
        chk("hold_count", int'(count), int'(fin));
      end
      if (r) req1 = 1'b0; else req0 = 1'b0;
    end
    tick();
    chk("job1_idle", int'(state), 0);
    mlast = r;
  endtask

  task automatic job2(input bit m0, input logic [3:0] s0, input bit m1, input logic [3:0] s1);
    bit w;
    w = ~mlast;
    push_exp(w, w ? m1 : m0, w ? s1 : s0);
    push_exp(!w, w ? m0 : m1, w ? s0 : s1);
    req0 = 1'b1; mode0 = m0; steps0 = s0;
    req1 = 1'b1; mode1 = m1; steps1 = s1;
    wait_ack(w, 60, "job2_first");
    if (w) req1 = 1'b0; else req0 = 1'b0;
    wait_ack(!w, 60, "job2_second");
    if (w) req0 = 1'b0; else req1 = 1'b0;
    tick();
    chk("job2_idle", int'(state), 0);
    mlast = !w;
  endtask

  // Monitor: tracks busy length and checks each completed job against the queue
  always @(negedge clock) begin
    exp_t e;
    bit   a;
    if (state == 2'b00) busy_cnt = 0;
    else if (busy === 1'b1) busy_cnt++;
    a = (ack0 | ack1);
    if (a && !ack_prev) begin
      chk("ack_exclusive", int'(ack0 & ack1), 0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ack: got ack0=%0d ack1=%0d, required none", ack0, ack1);
      end else begin
        e = exp_q.pop_front();
        chk("ack_owner", int'(ack1), int'(e.owner));
        chk("owner", int'(owner), int'(e.owner));
        chk("dir", int'(dir), int'(e.dir));
        chk("count", int'(count), int'(e.count));
        chk("busy_cycles", busy_cnt, e.n + 1);
      end
    end
    ack_prev = a;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         r, m, m2;
    logic [3:0] s, s2;
    req0 = 1'b0; mode0 = 1'b0; steps0 = 4'd0;
    req1 = 1'b0; mode1 = 1'b0; steps1 = 4'd0;
    do_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack0", int'(ack0), 0);
    chk("rst_ack1", int'(ack1), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_dir", int'(dir), 0);

    // V1: five steps up from zero
    job1(1'b0, 1'b0, 4'd5, 0, 1'b0);
    chk("v1_count", int'(count), 5);

    // V2: simultaneous requests after reset, requester 0 goes first
    do_reset();
    m = 1'($urandom); s = 4'($urandom);
    m2 = 1'($urandom); s2 = 4'($urandom);
    push_exp(1'b0, m, s);
    push_exp(1'b1, m2, s2);
    req0 = 1'b1; mode0 = m; steps0 = s;
    req1 = 1'b1; mode1 = m2; steps1 = s2;
    wait_ack(1'b0, 40, "v2_ack0");
    tick();
    chk("v2_ack0_held", int'(ack0), 1);
    chk("v2_done_held", int'(state), 3);
    req0 = 1'b0;
    tick();
    chk("v2_idle", int'(state), 0);
    tick();
    chk("v2_grant1_state", int'(state), 1);
    chk("v2_grant1_owner", int'(owner), 1);
    wait_ack(1'b1, 40, "v2_ack1");
    req1 = 1'b0;
    tick();
    chk("v2_end_idle", int'(state), 0);
    mlast = 1'b1;

    // V3: three steps down from zero wraps through 15
    do_reset();
    push_exp(1'b1, 1'b1, 4'd3);
    req1 = 1'b1; mode1 = 1'b1; steps1 = 4'd3;
    wait_state(2'b01, 5, "v3_load");
    tick();
    chk("v3_run", int'(state), 2);
    chk("v3_count_load", int'(count), 0);
    tick(); chk("v3_count1", int'(count), 15);
    tick(); chk("v3_count2", int'(count), 14);
    tick(); chk("v3_count3", int'(count), 13);
    chk("v3_ack1", int'(ack1), 1);
    chk("v3_dir", int'(dir), 1);
    req1 = 1'b0;
    tick();
    chk("v3_idle", int'(state), 0);
    mlast = 1'b1;

    // V4: zero-step job goes LOAD then DONE, counter untouched
    push_exp(1'b0, 1'b1, 4'd0);
    req0 = 1'b1; mode0 = 1'b1; steps0 = 4'd0;
    wait_state(2'b01, 5, "v4_load");
    tick();
    chk("v4_done", int'(state), 3);
    chk("v4_ack0", int'(ack0), 1);
    chk("v4_count", int'(count), 13);
    req0 = 1'b0;
    tick();
    chk("v4_idle", int'(state), 0);
    mlast = 1'b0;

    // Upward wrap 13+5 -> 2, then V6: owner holds request three extra cycles
    job1(1'b0, 1'b0, 4'd5, 0, 1'b0);
    chk("wrap_up_count", int'(count), 2);
    job1(1'b0, 1'b0, 4'd4, 3, 1'b0);
    // Request dropped during the job must not abort it
    job1(1'b1, 1'b1, 4'd6, 0, 1'b1);

    // V5: reset in the middle of a run, no ack must ever appear
    do_reset();
    req0 = 1'b1; mode0 = 1'b0; steps0 = 4'd10;
    for (int i = 0; i < 30 && count !== 4'd7; i++) tick();
    chk("v5_reach7", int'(count), 7);
    chk("v5_in_run", int'(state), 2);
    reset = 1'b1;
    req0  = 1'b0;
    tick();
    chk("v5_state", int'(state), 0);
    chk("v5_count", int'(count), 0);
    chk("v5_busy", int'(busy), 0);
    reset = 1'b0;
    mcount = 4'd0;
    mlast  = 1'b1;
    repeat (5) tick();

    // Randomized mix of single and contending jobs
    for (int it = 0; it < 40; it++) begin
      if (it % 13 == 12) do_reset();
      r  = 1'($urandom);
      m  = 1'($urandom);
      s  = 4'($urandom);
      m2 = 1'($urandom);
      s2 = 4'($urandom);
      case ($urandom_range(0, 3))
        0, 1: job1(r, m, s, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        2: job2(m, s, m2, s2);
        default: job1(r, m, ($urandom_range(0, 1) == 1) ? 4'd15 : 4'd0, 1, 1'b0);
      endcase
      chk("rand_count", int'(count), int'(mcount));
    end

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
